lfsr_rng_param: RTL and testbench

LFSR_RNG_PARAM -- requirements
Module: lfsr_rng_param

---
 rtl/lfsr_rng_param.sv | 108 ++++++++++
 tb/tb_lfsr_rng_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_param.sv
// Galois LFSR random-number source with a bounded-draw output register and
// valid/ready handshake, plus a wrapping count of completed handshakes.
module lfsr_rng_param #(
  parameter int unsigned      WIDTH = 16,
  parameter int unsigned      OUT_W = 4,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [OUT_W-1:0] bound,
  input  logic             rand_ready,
  output logic             rand_valid,
  output logic [OUT_W-1:0] rand_out,
  output logic [WIDTH-1:0] lfsr_state,
  output logic [15:0]      draw_cnt
);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_rng_param: WIDTH must be within 4..32");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_rng_param: OUT_W must be within 1..WIDTH");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_rng_param: TAPS must have its top bit set");
  end

  localparam logic [WIDTH-1:0] STATE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] galois_next;
  logic [WIDTH-1:0] seed_safe;
  logic [OUT_W-1:0] cand;
  logic             cand_ok;
  logic             out_open;
  logic             capture;
  logic             handshake;
  logic             valid_d;
  logic [OUT_W-1:0] out_d;

  assign galois_next = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
  assign seed_safe   = (seed == '0) ? STATE_ONE : seed;

  // An all-zero state is a fixed point of the LFSR, so it is escaped even when idle.
  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = seed_safe;
    end else if (state_q == '0) begin
      state_d = STATE_ONE;
    end else if (en) begin
      state_d = galois_next;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= STATE_ONE;
    end else begin
      state_q <= state_d;
    end
  end

  assign cand      = state_q[OUT_W-1:0];
  assign cand_ok   = (bound == '0) || (cand < bound);
  assign out_open  = !rand_valid || rand_ready;
  assign capture   = out_open && en && !seed_load && cand_ok;
  assign handshake = rand_valid && rand_ready;

  // A held value is never re-qualified against bound; only open cycles sample it.
  always_comb begin
    valid_d = rand_valid;
    out_d   = rand_out;
    if (seed_load) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      out_d   = cand;
    end else if (out_open) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rand_valid <= 1'b0;
      rand_out   <= '0;
    end else begin
      rand_valid <= valid_d;
      rand_out   <= out_d;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      draw_cnt <= '0;
    end else if (handshake) begin
      draw_cnt <= draw_cnt + 16'd1;
    end
  end

  assign lfsr_state = state_q;

endmodule

// File: tb/tb_lfsr_rng_param.sv
// Scoreboard bench for lfsr_rng_param: directed scenarios push expected draws,
// a negedge monitor pops and compares on every handshake.
module tb_lfsr_rng_param;

  logic        clk;
  logic        clr_n;
  logic        en;
  logic        seed_load;
  logic [3:0]  seed;
  logic [3:0]  bound;
  logic        rand_ready;
  logic        rand_valid;
  logic [3:0]  rand_out;
  logic [3:0]  lfsr_state;
  logic [15:0] draw_cnt;

  logic        clr2_n;
  logic        rand_valid2;
  logic [3:0]  rand_out2;
  logic [15:0] lfsr_state2;
  logic [15:0] draw_cnt2;

  int          nchk = 0;
  int          nerr = 0;
  logic [3:0]  exp_q[$];

  lfsr_rng_param #(.WIDTH(4), .OUT_W(4), .TAPS(4'hC)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .seed_load(seed_load), .seed(seed),
    .bound(bound), .rand_ready(rand_ready), .rand_valid(rand_valid),
    .rand_out(rand_out), .lfsr_state(lfsr_state), .draw_cnt(draw_cnt)
  );

  lfsr_rng_param dut_def (
    .clk(clk), .clr_n(clr2_n), .en(1'b1), .seed_load(1'b0), .seed(16'h0000),
    .bound(4'h0), .rand_ready(1'b1), .rand_valid(rand_valid2),
    .rand_out(rand_out2), .lfsr_state(lfsr_state2), .draw_cnt(draw_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    clr_n = 1'b0;
    #1;
    chk({tag, "_valid"}, rand_valid, 0);
    chk({tag, "_out"}, rand_out, 0);
    chk({tag, "_state"}, lfsr_state, 1);
    chk({tag, "_cnt"}, draw_cnt, 0);
  endtask

  always @(negedge clk) begin
    if (clr_n && rand_valid && rand_ready) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL draw_unexpected: got %0h expected none at %0t", rand_out, $time);
      end else begin
        chk("draw", rand_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] seq_full [16];
    logic [3:0] seq_b5 [5];
    seq_full = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
    seq_b5   = '{4'h1, 4'h3, 4'h4, 4'h2, 4'h1};

    clr_n = 1'b1; clr2_n = 1'b1; en = 1'b0; seed_load = 1'b0;
    seed = 4'h0; bound = 4'h0; rand_ready = 1'b1;
    #1;
    fork
      begin
        reset_pulse("rst_init");
        tick();
        // full-range period
        en = 1'b1; bound = 4'h0; rand_ready = 1'b1;
        foreach (seq_full[i]) exp_q.push_back(seq_full[i]);
        clr_n = 1'b1;
        tick(16);
        chk("full_cnt15", draw_cnt, 15);
        chk("full_last", rand_out, 4'h1);
        chk("full_state", lfsr_state, 4'hC);
        // en low: last handshake completes, then frozen
        en = 1'b0;
        tick();
        chk("enlow_cnt", draw_cnt, 16);
        chk("enlow_valid", rand_valid, 0);
        chk("enlow_state", lfsr_state, 4'hC);
        tick();
        chk("frozen_state", lfsr_state, 4'hC);
        chk("frozen_cnt", draw_cnt, 16);

        // bounded draws
        reset_pulse("rst_b");
        bound = 4'h5; en = 1'b1; rand_ready = 1'b1;
        foreach (seq_b5[i]) exp_q.push_back(seq_b5[i]);
        clr_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
          tick();
          if (k == 2 || k == 3) chk("reject_valid", rand_valid, 0);
          if (k == 4) chk("accept3", rand_out, 4'h3);
        end
        chk("bound_cnt", draw_cnt, 5);
        chk("bound_valid_end", rand_valid, 0);
        en = 1'b0;

        // backpressure
        reset_pulse("rst_c");
        bound = 4'h0; en = 1'b1; rand_ready = 1'b1;
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h5);
        clr_n = 1'b1;
        tick();
        rand_ready = 1'b0;
        chk("bp_first", rand_out, 4'h1);
        bound = 4'h1;
        for (int k = 2; k <= 6; k++) begin
          tick();
          chk("bp_hold_out", rand_out, 4'h1);
          chk("bp_hold_valid", rand_valid, 1);
        end
        chk("bp_state_adv", lfsr_state, 4'h5);
        chk("bp_cnt0", draw_cnt, 0);
        bound = 4'h0; rand_ready = 1'b1;
        tick();
        chk("bp_next", rand_out, 4'h5);
        chk("bp_cnt1", draw_cnt, 1);
        en = 1'b0;
        tick();
        chk("bp_cnt2", draw_cnt, 2);
        chk("bp_valid0", rand_valid, 0);

        // seed loads
        seed = 4'h0; seed_load = 1'b1; en = 1'b1;
        tick();
        chk("seed0_state", lfsr_state, 4'h1);
        chk("seed0_valid", rand_valid, 0);
        seed = 4'hA;
        tick();
        chk("seedA_state", lfsr_state, 4'hA);
        chk("seedA_valid", rand_valid, 0);
        chk("seedA_cnt", draw_cnt, 2);
        seed_load = 1'b0;
        exp_q.push_back(4'hA);
        tick();
        chk("seedA_cap", rand_out, 4'hA);
        chk("seedA_capv", rand_valid, 1);
        seed = 4'h3; seed_load = 1'b1;
        tick();
        chk("seed_hs_cnt", draw_cnt, 3);
        chk("seed_hs_valid", rand_valid, 0);
        chk("seed_hs_state", lfsr_state, 4'h3);
        seed_load = 1'b0;

        // reset while a value is pending
        rand_ready = 1'b0; en = 1'b1;
        tick();
        chk("pend_out", rand_out, 4'h3);
        chk("pend_valid", rand_valid, 1);
        reset_pulse("rst_mid");
        rand_ready = 1'b1;
        exp_q.push_back(4'h1);
        #1 clr_n = 1'b1;
        tick();
        chk("post_rst_out", rand_out, 4'h1);
        chk("post_rst_valid", rand_valid, 1);
        en = 1'b0;
        tick();
        chk("post_rst_cnt", draw_cnt, 1);
        chk("post_rst_valid0", rand_valid, 0);
      end
      begin
        int early;
        early = 0;
        clr2_n = 1'b0;
        #1;
        chk("def_rst_state", lfsr_state2, 1);
        @(posedge clk);
        #1;
        clr2_n = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
          @(posedge clk);
          #1;
          if (i < 65535 && lfsr_state2 == 16'h0001) early++;
          if (i == 65535) chk("def_period", lfsr_state2, 16'h0001);
        end
        chk("def_no_early", early, 0);
      end
    join
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
